// File: rtl/rx_word_aligner_pkg.sv
// Shared definitions for the receive word aligner: K28.5 code groups,
// 7-bit comma patterns, alignment FSM encoding and default thresholds.
// Build option: ALIGN_ANY_COMMA_EN widens comma detection to the 7-bit comma
// (so K28.1 / K28.7 also align); undefined means full K28.5 match only.
package rx_word_aligner_pkg;

    localparam logic [9:0] K285_RDN = 10'h0FA;
    localparam logic [9:0] K285_RDP = 10'h305;

    localparam logic [6:0] COMMA7_RDN = 7'b0011111;
    localparam logic [6:0] COMMA7_RDP = 7'b1100000;

    typedef enum logic [1:0] {
        ST_LOS  = 2'd0,
        ST_CD1  = 2'd1,
        ST_CD2  = 2'd2,
        ST_SYNC = 2'd3
    } align_state_t;

    localparam int COMMA_ACQ_DEF = 3;
    localparam int ERR_LIMIT_DEF = 4;
    localparam int GOOD_RUN_DEF  = 4;

    // True when the candidate code group counts as an alignment comma.
    function automatic logic is_comma(input logic [9:0] w);
`ifdef ALIGN_ANY_COMMA_EN
        return (w[9:3] == COMMA7_RDN) || (w[9:3] == COMMA7_RDP);
`else
        return (w == K285_RDN) || (w == K285_RDP);
`endif
    endfunction

endpackage

// File: rtl/rx_word_aligner_if.sv
// Bit-stream input and aligned code-group output bundle of the word aligner.
// master = line side / consumer (drives bits), slave = the aligner itself.
interface rx_word_aligner_if;
    import rx_word_aligner_pkg::*;

    logic       enb;
    logic       serial_in;
    logic [9:0] data10_out;
    logic       valid_out;
    logic       comma_out;
    logic       disp_err_out;
    logic       sync_out;

    modport master (
        output enb, serial_in,
        input  data10_out, valid_out, comma_out, disp_err_out, sync_out
    );

    modport slave (
        input  enb, serial_in,
        output data10_out, valid_out, comma_out, disp_err_out, sync_out
    );
endinterface

// File: rtl/rx_word_aligner_disp_checker.sv
// Combinational running-disparity check of one 10-bit code group.
// A group must carry 4, 5 or 6 ones, and an unbalanced group must move the
// running disparity toward the opposite sign.
module disp_checker
    import rx_word_aligner_pkg::*;
(
    input  logic [9:0] word,
    input  logic       rd_in,
    output logic       invalid,
    output logic       rd_out
);
    logic [3:0] ones;

    // Population count of the code group.
    always_comb begin
        ones = 4'd0;
        for (int i = 0; i < 10; i++) begin
            ones = ones + {3'b000, word[i]};
        end
    end

    // Validity against current RD and the RD that follows this group.
    always_comb begin
        invalid = 1'b0;
        rd_out  = rd_in;
        if (ones < 4'd4 || ones > 4'd6) begin
            invalid = 1'b1;
        end else if (ones == 4'd6 && rd_in) begin
            invalid = 1'b1;
        end else if (ones == 4'd4 && !rd_in) begin
            invalid = 1'b1;
        end
        if (ones == 4'd6) begin
            rd_out = 1'b1;
        end else if (ones == 4'd4) begin
            rd_out = 1'b0;
        end
    end
endmodule

// File: rtl/rx_word_aligner.sv
// Receive word aligner: shifts in one line bit per enabled clock, cuts the
// stream into 10-bit code groups, realigns on commas while not in sync and
// tracks link sync with an error-credit / good-run refund scheme.
// Build option: ALIGN_ANY_COMMA_EN (see package) selects 7-bit comma matching.
module rx_word_aligner
    import rx_word_aligner_pkg::*;
#(
    parameter int COMMA_ACQ = COMMA_ACQ_DEF,
    parameter int ERR_LIMIT = ERR_LIMIT_DEF,
    parameter int GOOD_RUN  = GOOD_RUN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    rx_word_aligner_if.slave link
);
    localparam logic [7:0] ACQ_N  = 8'(COMMA_ACQ);
    localparam logic [7:0] ERR_N  = 8'(ERR_LIMIT);
    localparam logic [7:0] GOOD_N = 8'(GOOD_RUN);

    logic [9:0]   window_q;
    logic [9:0]   data_q;
    logic [9:0]   nxt;
    logic [3:0]   bit_cnt_q;
    logic         valid_q;
    logic         comma_q;
    logic         derr_q;
    logic         rd_q;
    logic         rd_d;
    logic         rd_ones;
    align_state_t state_q;
    align_state_t state_d;
    logic [7:0]   acq_q;
    logic [7:0]   acq_d;
    logic [7:0]   err_q;
    logic [7:0]   err_d;
    logic [7:0]   good_q;
    logic [7:0]   good_d;
    logic         comma_hit;
    logic         aligned_end;
    logic         realign;
    logic         boundary;
    logic         word_invalid;
    logic         good_comma;
    logic         step;
    logic         sync_o;

    assign nxt         = {window_q[8:0], link.serial_in};
    assign comma_hit   = is_comma(nxt);
    assign aligned_end = (bit_cnt_q == 4'd9);
    // Once in sync the boundary is trusted; stray commas must not move it.
    assign realign     = comma_hit && !aligned_end && (state_q != ST_SYNC);
    assign boundary    = aligned_end || realign;
    assign good_comma  = comma_hit && !word_invalid;
    assign step        = link.enb && boundary;

    disp_checker u_disp (
        .word    (nxt),
        .rd_in   (rd_q),
        .invalid (word_invalid),
        .rd_out  (rd_ones)
    );

    // RD after the boundary word; a valid K28.5 lands on its ending disparity.
    always_comb begin
        rd_d = rd_ones;
        if (good_comma && nxt == K285_RDN) begin
            rd_d = 1'b1;
        end else if (good_comma && nxt == K285_RDP) begin
            rd_d = 1'b0;
        end
    end

    // Shift register, bit counter and registered word outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_q  <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            comma_q   <= 1'b0;
            derr_q    <= 1'b0;
            rd_q      <= 1'b0;
        end else if (link.enb) begin
            window_q <= nxt;
            if (boundary) begin
                data_q    <= nxt;
                valid_q   <= 1'b1;
                comma_q   <= comma_hit;
                derr_q    <= word_invalid;
                rd_q      <= rd_d;
                bit_cnt_q <= '0;
            end else begin
                valid_q   <= 1'b0;
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
        end
    end

    // Sync FSM state and its counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOS;
            acq_q   <= '0;
            err_q   <= '0;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            acq_q   <= acq_d;
            err_q   <= err_d;
            good_q  <= good_d;
        end
    end

    // Next-state logic, evaluated only on enabled word boundaries.
    always_comb begin
        state_d = state_q;
        acq_d   = acq_q;
        err_d   = err_q;
        good_d  = good_q;
        if (step) begin
            unique case (state_q)
                ST_LOS: begin
                    if (good_comma) begin
                        state_d = ST_CD1;
                        acq_d   = 8'd1;
                    end
                end
                ST_CD1, ST_CD2: begin
                    if (word_invalid) begin
                        state_d = ST_LOS;
                    end else if (comma_hit) begin
                        if (realign) begin
                            state_d = ST_CD1;
                            acq_d   = 8'd1;
                        end else if (acq_q >= ACQ_N - 8'd1) begin
                            state_d = ST_SYNC;
                            err_d   = '0;
                            good_d  = '0;
                        end else begin
                            state_d = ST_CD2;
                            acq_d   = acq_q + 8'd1;
                        end
                    end
                end
                ST_SYNC: begin
                    if (word_invalid) begin
                        good_d = '0;
                        err_d  = err_q + 8'd1;
                        if (err_q >= ERR_N - 8'd1) begin
                            state_d = ST_LOS;
                        end
                    end else if (err_q != 8'd0 && good_q >= GOOD_N - 8'd1) begin
                        err_d  = err_q - 8'd1;
                        good_d = '0;
                    end else if (good_q < GOOD_N) begin
                        good_d = good_q + 8'd1;
                    end
                end
                default: state_d = ST_LOS;
            endcase
        end
    end

    // Moore output of the FSM.
    always_comb begin
        sync_o = (state_q == ST_SYNC);
    end

    assign link.data10_out   = data_q;
    assign link.valid_out    = valid_q;
    assign link.comma_out    = comma_q;
    assign link.disp_err_out = derr_q;
    assign link.sync_out     = sync_o;
endmodule
